// File: rtl/oneapi_frame_sequencer.sv
// oneapi_frame_sequencer
// Frames an upstream pixel-beat stream into AXI4-Stream video: tlast marks
// the end of every line, tuser[0] marks the first beat of every frame.
// A single output register gives full throughput with one cycle of latency.
//
// Ports
//   csi_clk, rsi_reset             clock, async active-high reset
//   cfg_line_beats/frame_lines     frame geometry, sampled at each frame start
//   cfg_continuous                 auto-restart at frame end
//   ctrl_start / ctrl_stop         start pulse / stop request (frame completes)
//   sts_busy/frame_done/cfg_error  status; done and error are 1-cycle pulses
//   sts_frame_count                completed frames, wraps
//   us_t*                          upstream beats (valid/ready, no sideband)
//   axm_t*                         AXI4-Stream master
module oneapi_frame_sequencer #(
  parameter int BITS_AXI   = 64,
  parameter int TUSER_BITS = 8,
  parameter int DIM_BITS   = 16
) (
  input  logic                  csi_clk,
  input  logic                  rsi_reset,
  input  logic [DIM_BITS-1:0]   cfg_line_beats,
  input  logic [DIM_BITS-1:0]   cfg_frame_lines,
  input  logic                  cfg_continuous,
  input  logic                  ctrl_start,
  input  logic                  ctrl_stop,
  output logic                  sts_busy,
  output logic                  sts_frame_done,
  output logic                  sts_cfg_error,
  output logic [DIM_BITS-1:0]   sts_frame_count,
  input  logic                  us_tvalid,
  output logic                  us_tready,
  input  logic [BITS_AXI-1:0]   us_tdata,
  output logic                  axm_tvalid,
  input  logic                  axm_tready,
  output logic [BITS_AXI-1:0]   axm_tdata,
  output logic                  axm_tlast,
  output logic [TUSER_BITS-1:0] axm_tuser
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state, state_d;
  logic [DIM_BITS-1:0] line_beats_q, frame_lines_q;
  logic [DIM_BITS-1:0] beat_cnt, line_cnt;
  logic                sof, stop_pend;

  logic cfg_ok, accept, line_end, frame_end, stop_eff, relatch;

  assign cfg_ok    = (cfg_line_beats != '0) && (cfg_frame_lines != '0);
  assign accept    = us_tvalid && us_tready;
  assign line_end  = (beat_cnt == line_beats_q - DIM_BITS'(1));
  assign frame_end = line_end && (line_cnt == frame_lines_q - DIM_BITS'(1));
  // A stop arriving with the final beat still counts.
  assign stop_eff  = stop_pend || ctrl_stop;
  assign relatch   = cfg_continuous && !stop_eff;

  // State register
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) state <= IDLE;
    else           state <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (ctrl_start && cfg_ok) state_d = RUN;
      RUN:  if (accept && frame_end) state_d = (relatch && cfg_ok) ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    sts_busy  = (state == RUN);
    // The output register may hold a beat that is leaving this cycle.
    us_tready = (state == RUN) && (!axm_tvalid || axm_tready);
  end

  // Datapath, counters and status
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      line_beats_q    <= '0;
      frame_lines_q   <= '0;
      beat_cnt        <= '0;
      line_cnt        <= '0;
      sof             <= 1'b0;
      stop_pend       <= 1'b0;
      axm_tvalid      <= 1'b0;
      axm_tdata       <= '0;
      axm_tlast       <= 1'b0;
      axm_tuser       <= '0;
      sts_frame_done  <= 1'b0;
      sts_cfg_error   <= 1'b0;
      sts_frame_count <= '0;
    end else begin
      sts_frame_done <= 1'b0;
      sts_cfg_error  <= 1'b0;

      // Drains in any state; a new accept below overrides the clear.
      if (axm_tready) axm_tvalid <= 1'b0;

      if (state == IDLE && ctrl_start) begin
        if (cfg_ok) begin
          line_beats_q  <= cfg_line_beats;
          frame_lines_q <= cfg_frame_lines;
          beat_cnt      <= '0;
          line_cnt      <= '0;
          sof           <= 1'b1;
        end else begin
          sts_cfg_error <= 1'b1;
        end
      end

      if (accept) begin
        axm_tvalid <= 1'b1;
        axm_tdata  <= us_tdata;
        axm_tlast  <= line_end;
        axm_tuser  <= TUSER_BITS'(sof);
        sof        <= 1'b0;
        if (line_end) begin
          beat_cnt <= '0;
          line_cnt <= line_cnt + DIM_BITS'(1);
        end else begin
          beat_cnt <= beat_cnt + DIM_BITS'(1);
        end
        if (frame_end) begin
          sts_frame_done  <= 1'b1;
          sts_frame_count <= sts_frame_count + DIM_BITS'(1);
          line_cnt        <= '0;
          if (relatch) begin
            if (cfg_ok) begin
              line_beats_q  <= cfg_line_beats;
              frame_lines_q <= cfg_frame_lines;
              sof           <= 1'b1;
            end else begin
              sts_cfg_error <= 1'b1;
            end
          end
        end
      end

      if (state == RUN && ctrl_stop) stop_pend <= 1'b1;
      if (state_d == IDLE)           stop_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_oneapi_frame_sequencer.sv
module tb_oneapi_frame_sequencer;

  localparam int BW = 64;
  localparam int UW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] cfg_line_beats, cfg_frame_lines;
  logic          cfg_continuous, ctrl_start, ctrl_stop;
  logic          sts_busy, sts_frame_done, sts_cfg_error;
  logic [DW-1:0] sts_frame_count;
  logic          us_tvalid, us_tready;
  logic [BW-1:0] us_tdata;
  logic          axm_tvalid, axm_tready, axm_tlast;
  logic [BW-1:0] axm_tdata;
  logic [UW-1:0] axm_tuser;

  oneapi_frame_sequencer #(.BITS_AXI(BW), .TUSER_BITS(UW), .DIM_BITS(DW)) dut (
    .csi_clk(clk), .rsi_reset(rst),
    .cfg_line_beats(cfg_line_beats), .cfg_frame_lines(cfg_frame_lines),
    .cfg_continuous(cfg_continuous), .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop),
    .sts_busy(sts_busy), .sts_frame_done(sts_frame_done), .sts_cfg_error(sts_cfg_error),
    .sts_frame_count(sts_frame_count),
    .us_tvalid(us_tvalid), .us_tready(us_tready), .us_tdata(us_tdata),
    .axm_tvalid(axm_tvalid), .axm_tready(axm_tready), .axm_tdata(axm_tdata),
    .axm_tlast(axm_tlast), .axm_tuser(axm_tuser)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: beat k of a frame (0-based, lb*fl beats) is SOF when
  // k==0 and ends a line when k%lb==lb-1. Expected beats queue in order.
  typedef logic [BW+1+UW-1:0] beat_t;
  beat_t          expq[$];
  int             m_lb = 1, m_fl = 1, m_k = 0;
  int             acc_cnt = 0, deliv_cnt = 0, done_seen = 0, err_seen = 0, exp_done = 0;
  logic [DW-1:0]  fc_model = '0;
  logic           stall_p = 1'b0;
  beat_t          held;

  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      m_k      = 0;
      fc_model = '0;
      stall_p  = 1'b0;
    end else begin
      if (stall_p) begin
        chk("stall_valid", axm_tvalid, 1'b1);
        chk("stall_hold", {axm_tdata, axm_tlast, axm_tuser}, held);
      end
      if (axm_tvalid && axm_tready) begin
        if (expq.size() == 0) chk("unexpected_beat", 1'b1, 1'b0);
        else chk("beat", {axm_tdata, axm_tlast, axm_tuser}, expq.pop_front());
        deliv_cnt++;
      end
      if (us_tvalid && us_tready) begin
        expq.push_back({us_tdata, (m_k % m_lb) == m_lb - 1, UW'(m_k == 0)});
        acc_cnt++;
        m_k++;
        if (m_k == m_lb * m_fl) begin
          m_k = 0;
          exp_done++;
          fc_model = fc_model + 1'b1;
        end
      end
      if (sts_frame_done) done_seen++;
      if (sts_cfg_error)  err_seen++;
      stall_p = axm_tvalid && !axm_tready;
      held    = {axm_tdata, axm_tlast, axm_tuser};
    end
  end

  // Driver knobs
  int rdy_mode = 0;   // 0 always, 1 toggle, 2 random
  int vld_mode = 0;   // 0 always, 1 random
  int stop_at  = -1;  // assert ctrl_stop while this many beats have been accepted
  int acc_base = 0;

  task automatic step();
    @(posedge clk); #1;
    ctrl_start = 1'b0;
    ctrl_stop  = (stop_at >= 0) && (acc_cnt - acc_base == stop_at);
    case (rdy_mode)
      0: axm_tready = 1'b1;
      1: axm_tready = ~axm_tready;
      default: axm_tready = 1'($urandom_range(0, 1));
    endcase
    us_tvalid = (vld_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    us_tdata  = {$urandom, $urandom};
  endtask

  task automatic start(input int lb, input int fl, input logic cont);
    cfg_line_beats  = DW'(lb);
    cfg_frame_lines = DW'(fl);
    cfg_continuous  = cont;
    m_lb = lb;
    m_fl = fl;
    acc_base = acc_cnt;
    step();
    ctrl_start = 1'b1;
  endtask

  logic big_mode = 1'b0;

  task automatic run_idle(input int max);
    int n = 0;
    logic big_done = 1'b0;
    do begin
      step();
      n++;
      if (big_mode && !big_done && acc_cnt - acc_base == 65535) begin
        chk("fc_ffff", sts_frame_count, 16'hFFFF);
        big_done = 1'b1;
      end
    end while ((sts_busy || axm_tvalid) && n < max);
    chk("timeout", n < max, 1'b1);
    chk("idle_busy", sts_busy, 1'b0);
    chk("idle_q_empty", expq.size() == 0, 1'b1);
  endtask

  int d0, dn0, e0;

  initial begin
    rst = 1'b1;
    cfg_line_beats = '0; cfg_frame_lines = '0; cfg_continuous = 1'b0;
    ctrl_start = 1'b0; ctrl_stop = 1'b0;
    us_tvalid = 1'b0; us_tdata = '0; axm_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", axm_tvalid, 1'b0);
    chk("rst_tready", us_tready, 1'b0);
    chk("rst_busy", sts_busy, 1'b0);
    chk("rst_fc", sts_frame_count, '0);
    chk("rst_tuser", axm_tuser, '0);
    chk("rst_tdata", axm_tdata, '0);
    rst = 1'b0;

    // 4x2 single frame, full throughput
    d0 = deliv_cnt; dn0 = done_seen;
    start(4, 2, 1'b0);
    run_idle(50);
    chk("f1_beats", deliv_cnt - d0, 8);
    chk("f1_done", done_seen - dn0, 1);
    chk("f1_fc", sts_frame_count, 16'd1);

    // same config, downstream ready toggling
    rdy_mode = 1;
    d0 = deliv_cnt; dn0 = done_seen;
    start(4, 2, 1'b0);
    run_idle(80);
    chk("tog_beats", deliv_cnt - d0, 8);
    chk("tog_done", done_seen - dn0, 1);
    chk("tog_fc", sts_frame_count, fc_model);
    rdy_mode = 0;

    // continuous 3x1, stop during the second frame
    d0 = deliv_cnt; dn0 = done_seen;
    stop_at = 4;
    start(3, 1, 1'b1);
    run_idle(60);
    stop_at = -1;
    chk("cont_beats", deliv_cnt - d0, 6);
    chk("cont_done", done_seen - dn0, 2);

    // stop coincident with the final beat of the first frame
    d0 = deliv_cnt;
    stop_at = 1;
    start(2, 1, 1'b1);
    run_idle(40);
    stop_at = -1;
    chk("stop_last_beats", deliv_cnt - d0, 2);

    // continuous relatch with zero config; mid-frame cfg change must not matter
    d0 = deliv_cnt; e0 = err_seen;
    start(2, 1, 1'b1);
    step();
    cfg_line_beats = '0;
    run_idle(40);
    chk("zero_relatch_beats", deliv_cnt - d0, 2);
    chk("zero_relatch_err", err_seen - e0, 1);

    // start with zero line_beats
    start(0, 2, 1'b0);
    step();
    chk("cfgerr_pulse", sts_cfg_error, 1'b1);
    chk("cfgerr_busy", sts_busy, 1'b0);
    chk("cfgerr_tready", us_tready, 1'b0);
    step();
    chk("cfgerr_one_cycle", sts_cfg_error, 1'b0);

    // randomized frames, random valid/ready
    rdy_mode = 2; vld_mode = 1;
    for (int i = 0; i < 12; i++) begin
      int lb, fl;
      lb = $urandom_range(1, 5);
      fl = $urandom_range(1, 3);
      d0 = deliv_cnt; dn0 = done_seen;
      start(lb, fl, 1'b0);
      run_idle(400);
      chk("rnd_beats", deliv_cnt - d0, lb * fl);
      chk("rnd_done", done_seen - dn0, 1);
      chk("rnd_fc", sts_frame_count, fc_model);
    end
    rdy_mode = 0; vld_mode = 0;

    // reset after 5 beats of a 4x2 frame, then restart
    stop_at = -1;
    start(4, 2, 1'b0);
    while (acc_cnt - acc_base < 5) step();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", sts_busy, 1'b0);
    chk("midrst_tvalid", axm_tvalid, 1'b0);
    rst = 1'b0;
    start(4, 2, 1'b0);
    step(); step();
    chk("restart_sof_valid", axm_tvalid, 1'b1);
    chk("restart_sof", axm_tuser[0], 1'b1);
    chk("restart_fc0", sts_frame_count, '0);
    run_idle(50);
    chk("restart_fc1", sts_frame_count, 16'd1);

    // frame counter wrap: 65536 continuous 1x1 frames after reset
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    d0 = deliv_cnt;
    big_mode = 1'b1;
    stop_at = 65535;
    start(1, 1, 1'b1);
    run_idle(70000);
    big_mode = 1'b0;
    stop_at = -1;
    chk("wrap_beats", deliv_cnt - d0, 65536);
    chk("wrap_fc", sts_frame_count, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
